pc_seq_unit: RTL and testbench
==============================

Name: pc_seq_unit

Overview:
- Parametrised program-counter sequencer for the processor datapath; next generation of the simple R7/PC counter.
- Holds the PC and supports hold, increment, absolute load, PC-relative branch, call and return.
- Contains an internal return-address stack (RAS) so subroutine calls do not need to spill R7.
- Drives the instruction-fetch address and the R7 register-file mirror.

Parameters:
- PC_W, 9, PC width in bits; all PC arithmetic is modulo 2^PC_W.
- RAS_DEPTH, 4, number of return-address stack entries; must be at least 2.
- RESET_PC, 0, PC value after reset.

Ports:
- clk  input  1  clock, rising-edge.
- rst  input  1  asynchronous, active-low reset.
- en  input  1  advance enable; 0 = stall, all state frozen.
- incr  input  1  request pc+1.
- load  input  1  request absolute load of load_val (R7 write from the datapath).
- load_val  input  PC_W  absolute target for load or call.
- branch  input  1  request PC-relative branch.
- offset  input  PC_W  two's-complement branch offset.
- call  input  1  push pc+1, then jump to load_val.
- ret  input  1  pop the return address into pc.
- pc  output  PC_W  current PC, registered.
- r7  output  PC_W  PC value from the previous enabled cycle, registered.
- ras_empty  output  1  RAS holds 0 entries.
- ras_full  output  1  RAS holds RAS_DEPTH entries.
- ras_ovf  output  1  sticky flag: a call was made while the RAS was full.
- ras_unf  output  1  sticky flag: a return was made while the RAS was empty.

Behaviour:
- Reset (async, rst=0):
  - pc=RESET_PC, r7=RESET_PC.
  - RAS count=0 and pointer=0.
  - ras_empty=1, ras_full=0, ras_ovf=0, ras_unf=0.
  - RAS entry contents are don't-care.
- Reset asserted mid-operation aborts any in-flight operation immediately. No partial push or pop is retained.
- All updates happen on the rising clk edge when en=1. When en=0, pc, r7, the RAS and the flags all hold.
- Operation priority when several requests are high: ret > call > load > branch > incr > hold. Lower-priority requests are ignored that cycle.
- Operations (pc is the pre-edge value):
  - hold (no request): pc unchanged.
  - incr: pc <= pc+1. Wraps 2^PC_W-1 -> 0.
  - load: pc <= load_val.
  - branch: pc <= pc + offset, sign-extended, truncated to PC_W (wraps both ways).
  - call: push (pc+1 mod 2^PC_W), then pc <= load_val.
  - ret, RAS non-empty: pc <= top entry; pop.
  - ret, RAS empty: pc <= pc+1; ras_unf <= 1; RAS unchanged.
- Call when the RAS is full:
  - RAS is circular, so the oldest entry is overwritten.
  - Count stays RAS_DEPTH and ras_ovf <= 1.
  - Subsequent returns yield the newest RAS_DEPTH addresses.
- ras_ovf and ras_unf stay set until reset.
- r7 <= pc on every enabled edge, so r7 lags pc by one enabled cycle.
- Latency: 1 cycle from request to new pc. Outputs are registered; there is no combinational input-to-output path.
- ras_empty and ras_full are registered and reflect the count after the edge.

Decomposition:
- Package pc_seq_pkg:
  - pc_op_e enum: OP_HOLD, OP_INCR, OP_LOAD, OP_BRANCH, OP_CALL, OP_RET.
  - Function pc_op_decode(incr, load, branch, call, ret) that implements the priority order.
- Sub-module pc_ras: circular LIFO parametrised by PC_W and RAS_DEPTH.
  - Inputs: push, pop, din.
  - Outputs: top, empty, full, ovf_evt, unf_evt.
  - Top module contains pc/r7 registers, the next-PC mux and the sticky flags.

Test Plan:
- Reset then 3 incr cycles -> pc 0,1,2,3; r7 lags pc by one cycle; ras_empty=1.
- pc=510 (PC_W=9), incr x2 -> pc 511 then 0 (wrap). pc=5, branch offset=9'h1FD (-3) -> pc=2.
- pc=10, call load_val=100, then incr x2, then ret -> pc 100,101,102,11; ras_empty=1 after ret.
- 5 nested calls from pc=0,1,2,3,4 (RAS_DEPTH=4) -> ras_full=1, ras_ovf=1. Then 4 rets -> pc 5,4,3,2. A 5th ret -> pc+1 and ras_unf=1.
- pc=20 with call+load+incr high in one cycle -> call wins, pc=load_val, 21 pushed. en=0 for 3 cycles with incr=1 -> pc, r7 and RAS unchanged.
- rst pulsed low asynchronously, mid-cycle, after 2 calls -> pc=RESET_PC immediately, ras_empty=1, flags cleared.

Source files
------------

// File: rtl/pc_seq_pkg.sv
// Shared types for the program-counter sequencer: operation encoding and the
// request-priority decoder.
package pc_seq_pkg;

    localparam int unsigned PC_OP_W = 3;

    typedef enum logic [PC_OP_W-1:0] {
        OP_HOLD,
        OP_INCR,
        OP_LOAD,
        OP_BRANCH,
        OP_CALL,
        OP_RET
    } pc_op_e;

    // ret > call > load > branch > incr > hold
    function automatic pc_op_e pc_op_decode(
        input logic incr,
        input logic load,
        input logic branch,
        input logic call,
        input logic ret
    );
        if (ret)    return OP_RET;
        if (call)   return OP_CALL;
        if (load)   return OP_LOAD;
        if (branch) return OP_BRANCH;
        if (incr)   return OP_INCR;
        return OP_HOLD;
    endfunction

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack; a push while full overwrites the oldest entry
// so the newest RAS_DEPTH addresses are always retained.
module pc_ras #(
    parameter int unsigned PC_W      = 9,
    parameter int unsigned RAS_DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            push,
    input  logic            pop,
    input  logic [PC_W-1:0] din,
    output logic [PC_W-1:0] top,
    output logic            empty,
    output logic            full,
    output logic            ovf_evt,
    output logic            unf_evt
);

    localparam int unsigned PTR_W = $clog2(RAS_DEPTH);
    localparam int unsigned CNT_W = $clog2(RAS_DEPTH + 1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(RAS_DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(RAS_DEPTH);

    logic [PC_W-1:0]  mem [RAS_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] top_ptr;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             do_pop;

    // wr_ptr names the next free slot; the newest entry sits just behind it
    assign top_ptr = (wr_ptr == '0) ? PTR_LAST : wr_ptr - 1'b1;
    assign top     = mem[top_ptr];
    assign do_pop  = pop & ~empty;
    assign ovf_evt = push & full;
    assign unf_evt = pop & empty;

    always_comb begin
        cnt_nxt = cnt;
        if (push && !full) begin
            cnt_nxt = cnt + 1'b1;
        end else if (do_pop) begin
            cnt_nxt = cnt - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            cnt    <= '0;
            empty  <= 1'b1;
            full   <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;
            end else if (do_pop) begin
                wr_ptr <= top_ptr;
            end
            cnt   <= cnt_nxt;
            empty <= (cnt_nxt == '0);
            full  <= (cnt_nxt == CNT_FULL);
        end
    end

    // Entry storage needs no reset; contents are don't-care while empty
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= din;
        end
    end

endmodule

// File: rtl/pc_seq_unit.sv
// Program-counter sequencer: hold/incr/load/branch/call/ret with an internal
// return-address stack, fetch-address output and R7 mirror.
module pc_seq_unit
    import pc_seq_pkg::*;
#(
    parameter int unsigned PC_W      = 9,
    parameter int unsigned RAS_DEPTH = 4,
    parameter int unsigned RESET_PC  = 0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic            incr,
    input  logic            load,
    input  logic [PC_W-1:0] load_val,
    input  logic            branch,
    input  logic [PC_W-1:0] offset,
    input  logic            call,
    input  logic            ret,
    output logic [PC_W-1:0] pc,
    output logic [PC_W-1:0] r7,
    output logic            ras_empty,
    output logic            ras_full,
    output logic            ras_ovf,
    output logic            ras_unf
);

    localparam logic [PC_W-1:0] PC_RST = PC_W'(RESET_PC);

    pc_op_e          op;
    logic [PC_W-1:0] pc_nxt;
    logic [PC_W-1:0] pc_inc;
    logic [PC_W-1:0] ras_top;
    logic            push;
    logic            pop;
    logic            ovf_evt;
    logic            unf_evt;

    assign op     = pc_op_decode(incr, load, branch, call, ret);
    assign pc_inc = pc + 1'b1;

    // Next-PC mux; stack operations only fire on enabled cycles
    always_comb begin
        pc_nxt = pc;
        push   = 1'b0;
        pop    = 1'b0;
        case (op)
            OP_INCR:   pc_nxt = pc_inc;
            OP_LOAD:   pc_nxt = load_val;
            OP_BRANCH: pc_nxt = pc + offset;
            OP_CALL: begin
                push   = en;
                pc_nxt = load_val;
            end
            OP_RET: begin
                pop    = en;
                pc_nxt = ras_empty ? pc_inc : ras_top;
            end
            default: pc_nxt = pc;
        endcase
    end

    pc_ras #(
        .PC_W      (PC_W),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk     (clk),
        .rst     (rst),
        .push    (push),
        .pop     (pop),
        .din     (pc_inc),
        .top     (ras_top),
        .empty   (ras_empty),
        .full    (ras_full),
        .ovf_evt (ovf_evt),
        .unf_evt (unf_evt)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc      <= PC_RST;
            r7      <= PC_RST;
            ras_ovf <= 1'b0;
            ras_unf <= 1'b0;
        end else if (en) begin
            pc      <= pc_nxt;
            r7      <= pc;
            ras_ovf <= ras_ovf | ovf_evt;
            ras_unf <= ras_unf | unf_evt;
        end
    end

endmodule

// File: tb/tb_pc_seq_unit.sv
// Directed bench for pc_seq_unit: a queue-based reference model feeds a
// scoreboard of expected outputs, plus fixed pc checkpoints.
module tb_pc_seq_unit;

    typedef struct packed {
        logic [8:0] pc;
        logic [8:0] r7;
        logic       empty;
        logic       full;
        logic       ovf;
        logic       unf;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       incr;
    logic       load;
    logic [8:0] load_val;
    logic       branch;
    logic [8:0] offset;
    logic       call;
    logic       ret;
    logic [8:0] pc;
    logic [8:0] r7;
    logic       ras_empty;
    logic       ras_full;
    logic       ras_ovf;
    logic       ras_unf;

    int vectors     = 0;
    int miscompares = 0;

    exp_t       sb [$];
    logic [8:0] m_ras [$];
    logic [8:0] m_pc;
    logic [8:0] m_r7;
    logic       m_ovf;
    logic       m_unf;

    pc_seq_unit #(
        .PC_W      (9),
        .RAS_DEPTH (4),
        .RESET_PC  (0)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .incr      (incr),
        .load      (load),
        .load_val  (load_val),
        .branch    (branch),
        .offset    (offset),
        .call      (call),
        .ret       (ret),
        .pc        (pc),
        .r7        (r7),
        .ras_empty (ras_empty),
        .ras_full  (ras_full),
        .ras_ovf   (ras_ovf),
        .ras_unf   (ras_unf)
    );

    always #5 clk = ~clk;

    function automatic exp_t model_state();
        exp_t e;
        e.pc    = m_pc;
        e.r7    = m_r7;
        e.empty = (m_ras.size() == 0);
        e.full  = (m_ras.size() == 4);
        e.ovf   = m_ovf;
        e.unf   = m_unf;
        return e;
    endfunction

    function automatic exp_t dut_state();
        exp_t g;
        g.pc    = pc;
        g.r7    = r7;
        g.empty = ras_empty;
        g.full  = ras_full;
        g.ovf   = ras_ovf;
        g.unf   = ras_unf;
        return g;
    endfunction

    task automatic model_reset();
        m_pc  = 9'd0;
        m_r7  = 9'd0;
        m_ovf = 1'b0;
        m_unf = 1'b0;
        m_ras.delete();
    endtask

    task automatic check(input string tag, input exp_t got, input exp_t exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s observed pc=%0d r7=%0d e/f/o/u=%b%b%b%b expected pc=%0d r7=%0d e/f/o/u=%b%b%b%b",
                   tag, got.pc, got.r7, got.empty, got.full, got.ovf, got.unf,
                   exp.pc, exp.r7, exp.empty, exp.full, exp.ovf, exp.unf);
        end
    endtask

    task automatic chk_pc(input string tag, input logic [8:0] exp);
        vectors++;
        assert (pc === exp) else begin
            miscompares++;
            $error("FAIL %s observed pc=%0d expected pc=%0d", tag, pc, exp);
        end
    endtask

    // One clock of stimulus: model predicts, scoreboard holds, DUT is compared after the edge
    task automatic step(input string tag, input logic e_i, input logic i_i, input logic l_i,
                        input logic b_i, input logic c_i, input logic r_i,
                        input logic [8:0] lv, input logic [8:0] off);
        logic [8:0] npc;
        exp_t       ex;
        @(negedge clk);
        en = e_i; incr = i_i; load = l_i; branch = b_i; call = c_i; ret = r_i;
        load_val = lv; offset = off;
        if (e_i) begin
            npc = m_pc;
            if (r_i) begin
                if (m_ras.size() > 0) npc = m_ras.pop_back();
                else begin
                    npc   = m_pc + 9'd1;
                    m_unf = 1'b1;
                end
            end else if (c_i) begin
                if (m_ras.size() == 4) begin
                    void'(m_ras.pop_front());
                    m_ovf = 1'b1;
                end
                m_ras.push_back(m_pc + 9'd1);
                npc = lv;
            end else if (l_i) npc = lv;
            else if (b_i)     npc = m_pc + off;
            else if (i_i)     npc = m_pc + 9'd1;
            m_r7 = m_pc;
            m_pc = npc;
        end
        sb.push_back(model_state());
        @(posedge clk);
        #1;
        ex = sb.pop_front();
        check(tag, dut_state(), ex);
    endtask

    initial begin
        exp_t rst_exp;
        rst = 1'b0; en = 1'b0; incr = 1'b0; load = 1'b0; branch = 1'b0;
        call = 1'b0; ret = 1'b0; load_val = 9'd0; offset = 9'd0;
        model_reset();
        rst_exp = model_state();
        #12;
        check("reset", dut_state(), rst_exp);
        @(negedge clk);
        rst = 1'b1;

        // Counting from reset, r7 trailing
        step("incr1", 1, 1, 0, 0, 0, 0, 9'd0, 9'd0);   chk_pc("incr1_pc", 9'd1);
        step("incr2", 1, 1, 0, 0, 0, 0, 9'd0, 9'd0);   chk_pc("incr2_pc", 9'd2);
        step("incr3", 1, 1, 0, 0, 0, 0, 9'd0, 9'd0);   chk_pc("incr3_pc", 9'd3);

        // Wrap at the top of the address space, negative branch
        step("ld510", 1, 0, 1, 0, 0, 0, 9'd510, 9'd0);
        step("inc511", 1, 1, 0, 0, 0, 0, 9'd0, 9'd0);  chk_pc("inc511_pc", 9'd511);
        step("wrap0", 1, 1, 0, 0, 0, 0, 9'd0, 9'd0);   chk_pc("wrap0_pc", 9'd0);
        step("ld5", 1, 0, 1, 0, 0, 0, 9'd5, 9'd0);
        step("br_m3", 1, 0, 0, 1, 0, 0, 9'd0, 9'h1FD); chk_pc("br_m3_pc", 9'd2);
        step("br_fwd", 1, 0, 0, 1, 0, 0, 9'd0, 9'd510); chk_pc("br_fwd_pc", 9'd0);

        // Simple call/return
        step("ld10", 1, 0, 1, 0, 0, 0, 9'd10, 9'd0);
        step("call100", 1, 0, 0, 0, 1, 0, 9'd100, 9'd0); chk_pc("call100_pc", 9'd100);
        step("sub_inc1", 1, 1, 0, 0, 0, 0, 9'd0, 9'd0);
        step("sub_inc2", 1, 1, 0, 0, 0, 0, 9'd0, 9'd0);   chk_pc("sub_inc2_pc", 9'd102);
        step("ret11", 1, 0, 0, 0, 0, 1, 9'd0, 9'd0);      chk_pc("ret11_pc", 9'd11);

        // Nested calls overflow the 4-deep stack, then unwind past empty
        step("ld0", 1, 0, 1, 0, 0, 0, 9'd0, 9'd0);
        for (int i = 1; i <= 5; i++) begin
            step("nest_call", 1, 0, 0, 0, 1, 0, 9'(i), 9'd0);
        end
        for (int i = 0; i < 4; i++) begin
            step("nest_ret", 1, 0, 0, 0, 0, 1, 9'd0, 9'd0);
            chk_pc("nest_ret_pc", 9'(5 - i));
        end
        step("ret_unf", 1, 0, 0, 0, 0, 1, 9'd0, 9'd0);   chk_pc("ret_unf_pc", 9'd3);

        // Priority and stall
        step("ld20", 1, 0, 1, 0, 0, 0, 9'd20, 9'd0);
        step("prio_call", 1, 1, 1, 0, 1, 0, 9'd77, 9'd0); chk_pc("prio_call_pc", 9'd77);
        for (int i = 0; i < 3; i++) begin
            step("stall", 0, 1, 0, 0, 0, 0, 9'd0, 9'd0);
        end
        step("prio_ret", 1, 1, 1, 1, 1, 1, 9'd300, 9'd4); chk_pc("prio_ret_pc", 9'd21);

        // Asynchronous reset mid-cycle after two calls
        step("pre_call1", 1, 0, 0, 0, 1, 0, 9'd200, 9'd0);
        step("pre_call2", 1, 0, 0, 0, 1, 0, 9'd250, 9'd0);
        en = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        check("async_rst", dut_state(), model_state());
        @(negedge clk);
        rst = 1'b1;
        step("post_rst_inc", 1, 1, 0, 0, 0, 0, 9'd0, 9'd0); chk_pc("post_rst_pc", 9'd1);
        step("post_rst_ret", 1, 0, 0, 0, 0, 1, 9'd0, 9'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
